// File: rtl/seg7_scan_if.sv
// Record stream carrying one decoded digit per transfer (valid/ready handshake).
interface seg7_scan_if;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_index;
  logic [3:0] out_value;
  logic       out_ok;
  logic       out_dp;

  modport master (output out_valid, out_index, out_value, out_ok, out_dp,
                  input  out_ready);
  modport slave  (input  out_valid, out_index, out_value, out_ok, out_dp,
                  output out_ready);
endinterface

// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment line reader: sync, debounce, decode to hex, emit changed digits.
// Define SEG7_SCAN_ERR_EN to add the saturating err_count port.
module seg7_scan_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  bits_in,
  seg7_scan_if.master out
`ifdef SEG7_SCAN_ERR_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Returns {ok, value}; lit is active-high a..g with a in bit 6.
  function automatic logic [4:0] encode(input logic [6:0] lit);
    case (lit)
      7'h7E: encode = {1'b1, 4'h0};
      7'h30: encode = {1'b1, 4'h1};
      7'h6D: encode = {1'b1, 4'h2};
      7'h79: encode = {1'b1, 4'h3};
      7'h33: encode = {1'b1, 4'h4};
      7'h5B: encode = {1'b1, 4'h5};
      7'h5F: encode = {1'b1, 4'h6};
      7'h70: encode = {1'b1, 4'h7};
      7'h7F: encode = {1'b1, 4'h8};
      7'h7B: encode = {1'b1, 4'h9};
      7'h77: encode = {1'b1, 4'hA};
      7'h1F: encode = {1'b1, 4'hB};
      7'h4E: encode = {1'b1, 4'hC};
      7'h3D: encode = {1'b1, 4'hD};
      7'h4F: encode = {1'b1, 4'hE};
      7'h47: encode = {1'b1, 4'hF};
      default: encode = 5'b0;
    endcase
  endfunction

  logic [7:0]       seg_p0, seg_p1, seg_p2;
  logic [3:0]       bits_p0, bits_p1, bits_p2;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             legal, same, accept, changed;
  logic [1:0]       sel;
  logic [5:0]       rec;
  logic [5:0]       store [4];
  logic [3:0]       seen, pending, set_mask, clr_mask;
  logic             load, found;
  logic [1:0]       pick;

  // Stage p0/p1: two-flop synchronizer, idle level is all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0  <= '1;
      seg_p1  <= '1;
      bits_p0 <= '1;
      bits_p1 <= '1;
    end else begin
      seg_p0  <= seg_in;
      seg_p1  <= seg_p0;
      bits_p0 <= bits_in;
      bits_p1 <= bits_p0;
    end
  end

  always_comb begin
    legal = 1'b0;
    sel   = 2'd0;
    case (bits_p1)
      4'b1110: begin legal = 1'b1; sel = 2'd0; end
      4'b1101: begin legal = 1'b1; sel = 2'd1; end
      4'b1011: begin legal = 1'b1; sel = 2'd2; end
      4'b0111: begin legal = 1'b1; sel = 2'd3; end
      default: ;
    endcase
  end

  assign same = ({bits_p1, seg_p1} == {bits_p2, seg_p2});

  always_comb begin
    cnt_next = '0;
    if (legal) begin
      if (!same)               cnt_next = CNT_W'(1);
      else if (cnt == CNT_MAX) cnt_next = CNT_MAX;
      else                     cnt_next = cnt + CNT_W'(1);
    end
  end

  // A saturated counter only re-fires when the sample itself changed.
  assign accept  = legal && (cnt_next == CNT_MAX) && !(same && cnt == CNT_MAX);
  assign rec     = {encode(~seg_p1[7:1]), ~seg_p1[0]};
  assign changed = accept && (!seen[sel] || store[sel] != rec);
  assign set_mask = changed ? (4'b0001 << sel) : 4'b0000;

  // Stage p2: previous sample, stability counter, per-digit store
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p2  <= '1;
      bits_p2 <= '1;
      cnt     <= '0;
      seen    <= '0;
    end else begin
      seg_p2  <= seg_p1;
      bits_p2 <= bits_p1;
      cnt     <= cnt_next;
      if (changed) seen[sel] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (changed) store[sel] <= rec;
  end

  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

  assign load     = !out.out_valid || out.out_ready;
  assign clr_mask = (load && found) ? (4'b0001 << pick) : 4'b0000;

  // Output stage: a new accept on the digit being loaded keeps it pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      out.out_valid <= 1'b0;
      out.out_index <= '0;
      out.out_value <= '0;
      out.out_ok    <= 1'b0;
      out.out_dp    <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (load) begin
        out.out_valid <= found;
        if (found) begin
          out.out_index <= pick;
          out.out_ok    <= store[pick][5];
          out.out_value <= store[pick][4:1];
          out.out_dp    <= store[pick][0];
        end
      end
    end
  end

`ifdef SEG7_SCAN_ERR_EN
  logic err_inc;
  assign err_inc = (accept && !rec[5]) || (!legal && bits_p1 != bits_p2);

  always_ff @(posedge clk) begin
    if (rst)                                err_count <= '0;
    else if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with STABLE_CYCLES = 4.
module tb_seg7_scan_reader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_in;
  logic [3:0] bits_in;
  int         checks = 0;
  int         errors = 0;
  int         vcount;
`ifdef SEG7_SCAN_ERR_EN
  logic [15:0] err_count;
  int          err_base;
`endif

  seg7_scan_if bus();

  seg7_scan_reader #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .bits_in (bits_in),
    .out     (bus)
`ifdef SEG7_SCAN_ERR_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rec(input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (bus.out_valid) hit = 1'b1;
    end
    check_eq({tag, "_arrive"}, 32'(hit), 32'd1);
  endtask

  task automatic check_rec(input string tag, input int idx, input int val, input int ok, input int dp);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_index"}, 32'(bus.out_index), 32'(idx));
    check_eq({tag, "_value"}, 32'(bus.out_value), 32'(val));
    check_eq({tag, "_ok"},    32'(bus.out_ok),    32'(ok));
    check_eq({tag, "_dp"},    32'(bus.out_dp),    32'(dp));
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.out_valid) c++;
    end
  endtask

  initial begin
    rst = 1'b1;
    seg_in = 8'hFF;
    bits_in = 4'hF;
    bus.out_ready = 1'b1;
    step(3);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_index", 32'(bus.out_index), 32'd0);
    check_eq("rst_value", 32'(bus.out_value), 32'd0);
    check_eq("rst_ok",    32'(bus.out_ok),    32'd0);
    check_eq("rst_dp",    32'(bus.out_dp),    32'd0);
`ifdef SEG7_SCAN_ERR_EN
    check_eq("rst_err", 32'(err_count), 32'd0);
`endif

    // Single digit 2 showing "3": record appears exactly 7 edges later
    rst = 1'b0;
    bits_in = 4'b1011;
    seg_in = 8'h0D;
    step(6);
    check_eq("lat_early", 32'(bus.out_valid), 32'd0);
    step(1);
    check_rec("single", 2, 3, 1, 0);
    step(1);
    check_eq("single_drop", 32'(bus.out_valid), 32'd0);
    count_valid(10, vcount);
    check_eq("single_quiet", 32'(vcount), 32'd0);

    // Debounce: toggling every 3 cycles never settles
    for (int k = 0; k < 8; k++) begin
      seg_in = (k % 2 == 0) ? 8'h9F : 8'h0D;
      count_valid(3, vcount);
      check_eq("bounce_quiet", 32'(vcount), 32'd0);
    end
    seg_in = 8'h9F;
    wait_rec("bounce");
    check_rec("bounce", 2, 1, 1, 0);
    step(1);
    check_eq("bounce_drop", 32'(bus.out_valid), 32'd0);

    // Backpressure: digits 0 ("8"), 1 ("5"), 3 ("A") while consumer stalls
    bus.out_ready = 1'b0;
    bits_in = 4'b1110; seg_in = 8'h01; step(8);
    check_rec("bp_d0", 0, 8, 1, 0);
    bits_in = 4'b1101; seg_in = 8'h49; step(8);
    check_rec("bp_hold1", 0, 8, 1, 0);
    bits_in = 4'b0111; seg_in = 8'h11; step(8);
    check_rec("bp_hold3", 0, 8, 1, 0);
    bits_in = 4'b1111; seg_in = 8'hFF;
    step(2);
    bus.out_ready = 1'b1;
    step(1);
    check_rec("bp_rel1", 1, 5, 1, 0);
    step(1);
    check_rec("bp_rel3", 3, 10, 1, 0);
    step(1);
    check_eq("bp_drop", 32'(bus.out_valid), 32'd0);

    // Set-wins: digit 0 re-accepted on the edge its pending record is loaded
    bus.out_ready = 1'b0;
    bits_in = 4'b1101; seg_in = 8'h25; step(8);
    check_rec("sw_d1", 1, 2, 1, 0);
    bits_in = 4'b1110; seg_in = 8'h1F; step(8);
    seg_in = 8'h09;
    step(5);
    bus.out_ready = 1'b1;
    step(1);
    check_rec("sw_old", 0, 7, 1, 0);
    step(1);
    check_rec("sw_new", 0, 9, 1, 0);
    step(1);
    check_eq("sw_drop", 32'(bus.out_valid), 32'd0);

    // Illegal select and unknown pattern
`ifdef SEG7_SCAN_ERR_EN
    err_base = int'(err_count);
`endif
    bits_in = 4'b0011; seg_in = 8'h0D;
    count_valid(10, vcount);
    check_eq("illegal_quiet", 32'(vcount), 32'd0);
`ifdef SEG7_SCAN_ERR_EN
    check_eq("illegal_err", 32'(err_count), 32'(err_base + 1));
`endif
    bits_in = 4'b1110; seg_in = 8'hFE;
    wait_rec("dponly");
    check_rec("dponly", 0, 0, 0, 1);
`ifdef SEG7_SCAN_ERR_EN
    check_eq("dponly_err", 32'(err_count), 32'(err_base + 2));
`endif
    step(1);
    check_eq("dponly_drop", 32'(bus.out_valid), 32'd0);

    // Reset while a record is held drops it
    bus.out_ready = 1'b0;
    bits_in = 4'b1011; seg_in = 8'h0D;
    wait_rec("midrst");
    check_rec("midrst", 2, 3, 1, 0);
    rst = 1'b1;
    step(1);
    check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_value", 32'(bus.out_value), 32'd0);
    check_eq("midrst_index", 32'(bus.out_index), 32'd0);
`ifdef SEG7_SCAN_ERR_EN
    check_eq("midrst_err", 32'(err_count), 32'd0);
`endif
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
